bit_stream_serializer: RTL and testbench
========================================

Name: bit_stream_serializer

Overview:
- Parallel-to-serial source that sits directly upstream of the serial sequence-detector FSM.
- Accepts WIDTH-bit words over a valid/ready load interface and presents them one bit per clock on ser_out; ser_out drives the detector's serial input.
- A one-word holding buffer allows back-to-back words with no idle bit between them.
- Reports per-word completion and keeps a running count of words sent.

Parameters:
- WIDTH, 8, bits per word; legal range 2 to 32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_BIT, 0, value driven on ser_out when no word is being shifted.
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- load_valid  input  1  load_data holds a word to transfer.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit to downstream detector.
- ser_valid  output  1  ser_out carries a data bit (not idle fill).
- word_done  output  1  high during the cycle the last bit of a word is on ser_out.
- words_sent  output  CNT_W  count of fully transmitted words; wraps.

Behaviour:
- Reset (rst=0, async, immediate):
  - ser_out=IDLE_BIT, ser_valid=0, word_done=0, words_sent=0, load_ready=1.
  - Shift register, bit counter and buffer-full flag are cleared; state is IDLE.
  - A reset mid-word aborts the word and discards the buffered word; that word is not counted.
- Handshake:
  - A transfer occurs on a posedge where load_valid=1 and load_ready=1.
  - load_ready equals !buf_full, driven from the flop; there is no combinational path from load_valid to load_ready.
- State IDLE:
  - Transfer at edge N loads the shifter directly; state becomes SHIFT and bit count = 0.
  - From edge N, ser_out = first bit and ser_valid=1. Latency is one cycle.
- State SHIFT:
  - Each posedge advances one bit; ser_out, ser_valid and word_done are all registered.
  - A transfer during SHIFT writes the buffer and sets buf_full, so load_ready=0 from the next cycle.
- Last bit (count = WIDTH-1) presented in a cycle: word_done=1 that cycle. At the closing edge, words_sent increments (mod 2^CNT_W), then:
  - buf_full=1: buffer moves to the shifter, buf_full clears, count=0, state stays SHIFT. The next word's first bit follows with no gap.
  - buf_full=0 and a transfer occurs at this edge: the new word loads the shifter directly; no gap.
  - Otherwise: state becomes IDLE, ser_out=IDLE_BIT, ser_valid=0, word_done=0.
- Simultaneous events:
  - Buffer drain and a new load on the same edge cannot both occur, because load_ready was 0. A new load is accepted one cycle later and lands in the now-empty buffer.
- Bit order: MSB_FIRST=1 emits load_data[WIDTH-1] down to [0]; MSB_FIRST=0 emits [0] up to [WIDTH-1].
- Throughput: exactly WIDTH cycles per word with continuous supply.

Test Plan:
1. Assert rst=0 mid-cycle with load_valid=1 -> outputs immediately ser_out=0, ser_valid=0, load_ready=1, words_sent=0; no transfer while rst=0.
2. WIDTH=8, MSB_FIRST=1: load 8'hA5 at edge 0 -> ser_out = 1,0,1,0,0,1,0,1 in cycles 1–8; ser_valid=1 for those cycles; word_done=1 only in cycle 8; cycle 9 ser_valid=0, ser_out=0; words_sent=1.
3. Back-to-back: load 8'hF0 at edge 0, 8'h0F at edge 1 -> load_ready=0 in cycles 2–8; 16 contiguous valid bits 1111000000001111 in cycles 1–16; word_done in cycles 8 and 16; words_sent=2.
4. MSB_FIRST=0, IDLE_BIT=1: load 8'h01 -> bits 1,0,0,0,0,0,0,0, then ser_out returns to 1 with ser_valid=0.
5. Load 8'hFF, pull rst low after 3 bits with a second word buffered -> ser_valid=0 and load_ready=1 immediately; after release, no residual bits; words_sent=0.
6. CNT_W=4: stream 17 words continuously -> words_sent reads 15 after word 15, 0 after word 16, 1 after word 17; no gaps in ser_valid across the wrap.

Source files
------------

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial word source feeding a serial detector, with a one-word
// holding buffer so consecutive words stream without idle bits between them.
module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic [CNT_W-1:0] words_sent
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             nxt_state_s;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   nxt_shift_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      nxt_cnt_s;
    logic [WIDTH-1:0]   buf_r;
    logic [WIDTH-1:0]   nxt_buf_s;
    logic               buf_full_r;
    logic               nxt_buf_full_s;
    logic               ser_out_r;
    logic               ser_valid_r;
    logic               word_done_r;
    logic [CNT_W-1:0]   words_sent_r;
    logic               xfer_s;
    logic               last_s;

    // The bit on the wire is always the head of the shifter, whichever end that is.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign load_ready = !buf_full_r;
    assign xfer_s     = load_valid && !buf_full_r;
    assign last_s     = (state_r == ST_SHIFT) && (cnt_r == LAST_CNT);

    assign ser_out    = ser_out_r;
    assign ser_valid  = ser_valid_r;
    assign word_done  = word_done_r;
    assign words_sent = words_sent_r;

    // Next-state logic for the shifter, bit counter and holding buffer.
    always_comb begin
        nxt_state_s    = state_r;
        nxt_shift_s    = shift_r;
        nxt_cnt_s      = cnt_r;
        nxt_buf_s      = buf_r;
        nxt_buf_full_s = buf_full_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    nxt_shift_s = load_data;
                    nxt_cnt_s   = {CW{1'b0}};
                    nxt_state_s = ST_SHIFT;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    // Buffered word wins; a direct load can only happen with an empty buffer.
                    if (buf_full_r) begin
                        nxt_shift_s    = buf_r;
                        nxt_buf_full_s = 1'b0;
                        nxt_cnt_s      = {CW{1'b0}};
                    end else if (xfer_s) begin
                        nxt_shift_s = load_data;
                        nxt_cnt_s   = {CW{1'b0}};
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end else begin
                    nxt_shift_s = advance(shift_r);
                    nxt_cnt_s   = cnt_r + CW'(1);
                    if (xfer_s) begin
                        nxt_buf_s      = load_data;
                        nxt_buf_full_s = 1'b1;
                    end else begin
                        nxt_buf_full_s = buf_full_r;
                    end
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            buf_r      <= {WIDTH{1'b0}};
            buf_full_r <= 1'b0;
        end else begin
            state_r    <= nxt_state_s;
            shift_r    <= nxt_shift_s;
            cnt_r      <= nxt_cnt_s;
            buf_r      <= nxt_buf_s;
            buf_full_r <= nxt_buf_full_s;
        end
    end

    // Outputs are registered from the next-state view so a word's first bit appears right after its load edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_out_r    <= IDLE_BIT;
            ser_valid_r  <= 1'b0;
            word_done_r  <= 1'b0;
            words_sent_r <= {CNT_W{1'b0}};
        end else begin
            ser_out_r   <= (nxt_state_s == ST_SHIFT) ? head_bit(nxt_shift_s) : IDLE_BIT;
            ser_valid_r <= (nxt_state_s == ST_SHIFT);
            word_done_r <= (nxt_state_s == ST_SHIFT) && (nxt_cnt_s == LAST_CNT);
            if (last_s) begin
                words_sent_r <= words_sent_r + CNT_W'(1);
            end else begin
                words_sent_r <= words_sent_r;
            end
        end
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench for bit_stream_serializer: three instances cover MSB-first,
// LSB-first with high idle fill, and a narrow wrapping word counter.
module tb_bit_stream_serializer;

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [7:0] seq;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        lv [3];
    logic [7:0]  ld [3];
    logic        lr [3];
    logic        so [3];
    logic        sv [3];
    logic        wd [3];
    logic [15:0] ws0;
    logic [15:0] ws1;
    logic [3:0]  ws2;

    exp_t        q [3][$];
    int          exp_ws [3];
    int          total;
    int          bad;
    int          gaps;
    bit          started2;

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .word_done(wd[0]), .words_sent(ws0));

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .word_done(wd[1]), .words_sent(ws1));

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(lr[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .word_done(wd[2]), .words_sent(ws2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic idle_val(input int k);
        return (k == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic mon_one(input int k);
        exp_t        e;
        logic [31:0] ws_act;
        logic [31:0] ws_exp;
        ws_act = (k == 0) ? 32'(ws0) : (k == 1) ? 32'(ws1) : 32'(ws2);
        ws_exp = (k == 2) ? (32'(exp_ws[k]) & 32'h0000_000F) : (32'(exp_ws[k]) & 32'h0000_FFFF);
        chk($sformatf("words_sent%0d", k), ws_act, ws_exp);
        if (sv[k]) begin
            if (q[k].size() == 0) begin
                chk($sformatf("spurious_valid%0d", k), 32'(sv[k]), 32'd0);
            end else begin
                e = q[k].pop_front();
                chk($sformatf("ser_out%0d", k), 32'(so[k]), 32'(e.b));
                chk($sformatf("word_done%0d", k), 32'(wd[k]), 32'(e.d));
                if (e.d) exp_ws[k]++;
                if (k == 2) started2 = 1'b1;
            end
        end else begin
            chk($sformatf("idle_out%0d", k), 32'(so[k]), 32'(idle_val(k)));
            chk($sformatf("idle_done%0d", k), 32'(wd[k]), 32'd0);
            if (k == 2 && started2 && q[2].size() > 0) gaps++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) mon_one(k);
    endtask

    task automatic send(input int k, input logic [7:0] data, input logic [7:0] seq);
        bit acc;
        for (int i = 0; i < 8; i++) q[k].push_back('{b: seq[7-i], d: (i == 7)});
        lv[k] = 1'b1;
        ld[k] = data;
        acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) begin
            acc = lr[k];
            tick();
        end
        lv[k] = 1'b0;
        chk($sformatf("accept%0d", k), 32'(acc), 32'd1);
    endtask

    task automatic drain(input int k);
        for (int n = 0; n < 40 && q[k].size() > 0; n++) tick();
        chk($sformatf("drained%0d", k), 32'(q[k].size()), 32'd0);
        tick();
        chk($sformatf("after_valid%0d", k), 32'(sv[k]), 32'd0);
        chk($sformatf("after_out%0d", k), 32'(so[k]), 32'(idle_val(k)));
    endtask

    // Assert reset away from the clock edge and check it acts immediately.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), 32'(sv[k]), 32'd0);
            chk($sformatf("rst_ready%0d", k), 32'(lr[k]), 32'd1);
            chk($sformatf("rst_out%0d", k), 32'(so[k]), 32'(idle_val(k)));
            q[k].delete();
            exp_ws[k] = 0;
        end
        chk("rst_ws0", 32'(ws0), 32'd0);
        started2 = 1'b0;
        gaps = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t tbl [6];

    initial begin
        total = 0;
        bad = 0;
        gaps = 0;
        started2 = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lv[k] = 1'b0;
            ld[k] = 8'h00;
            exp_ws[k] = 0;
        end
        tbl[0] = '{inst: 0, data: 8'hA5, seq: 8'hA5};
        tbl[1] = '{inst: 0, data: 8'h3C, seq: 8'h3C};
        tbl[2] = '{inst: 0, data: 8'h80, seq: 8'h80};
        tbl[3] = '{inst: 1, data: 8'h01, seq: 8'h80};
        tbl[4] = '{inst: 1, data: 8'hC1, seq: 8'h83};
        tbl[5] = '{inst: 1, data: 8'h36, seq: 8'h6C};

        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset asserted with a word offered: nothing may transfer.
        lv[0] = 1'b1;
        ld[0] = 8'hA5;
        do_reset();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_hold_valid", 32'(sv[0]), 32'd0);
        chk("rst_hold_ws", 32'(ws0), 32'd0);
        lv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single word A5, MSB first: one-cycle latency, done on the eighth bit.
        do_reset();
        send(0, 8'hA5, 8'hA5);
        chk("lat_valid", 32'(sv[0]), 32'd1);
        chk("lat_bit", 32'(so[0]), 32'd1);
        drain(0);
        chk("single_ws", 32'(ws0), 32'd1);

        // Back-to-back F0 then 0F through the holding buffer.
        do_reset();
        send(0, 8'hF0, 8'hF0);
        chk("b2b_c1_valid", 32'(sv[0]), 32'd1);
        send(0, 8'h0F, 8'h0F);
        for (int c = 2; c <= 8; c++) begin
            chk("b2b_ready_low", 32'(lr[0]), 32'd0);
            chk("b2b_valid_a", 32'(sv[0]), 32'd1);
            tick();
        end
        for (int c = 9; c <= 16; c++) begin
            chk("b2b_ready_high", 32'(lr[0]), 32'd1);
            chk("b2b_valid_b", 32'(sv[0]), 32'd1);
            tick();
        end
        chk("b2b_end_valid", 32'(sv[0]), 32'd0);
        chk("b2b_ws", 32'(ws0), 32'd2);

        // Table of isolated words on both bit orders.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].inst, tbl[i].data, tbl[i].seq);
            drain(tbl[i].inst);
        end
        chk("tbl_ws0", 32'(ws0), 32'd3);
        chk("tbl_ws1", 32'(ws1), 32'd3);
        chk("lsb_idle_high", 32'(so[1]), 32'd1);

        // Reset mid-word with a second word buffered.
        do_reset();
        send(0, 8'hFF, 8'hFF);
        send(0, 8'h55, 8'h55);
        tick();
        chk("abort_busy", 32'(lr[0]), 32'd0);
        do_reset();
        for (int n = 0; n < 12; n++) tick();
        chk("abort_ws", 32'(ws0), 32'd0);
        chk("abort_valid", 32'(sv[0]), 32'd0);

        // 17 continuous words on a 4-bit counter: wrap without gaps.
        do_reset();
        for (int w = 0; w < 17; w++) begin
            logic [7:0] d;
            d = 8'(w * 37 + 5);
            send(2, d, d);
        end
        drain(2);
        chk("wrap_ws", 32'(ws2), 32'd1);
        chk("wrap_gaps", 32'(gaps), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
